// File: rtl/regfile_seq_pkg.sv
// Shared types and constants for the register-file sequencer.
package regfile_seq_pkg;

  localparam int unsigned DW_DEF = 10;
  localparam int unsigned AW_DEF = 2;
  localparam int unsigned IW     = 10;
  localparam int unsigned OPW    = 4;

  typedef enum logic [OPW-1:0] {
    OP_LOAD  = 4'h0,
    OP_STORE = 4'h1,
    OP_MOV   = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_XOR   = 4'h5,
    OP_INC   = 4'h6
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Instruction word layout: [9:6] op, [5:4] rx, [3:2] ry, [1:0] reserved
  typedef struct packed {
    logic [OPW-1:0]    op;
    logic [AW_DEF-1:0] rx;
    logic [AW_DEF-1:0] ry;
    logic [1:0]        rsvd;
  } instr_t;

  // Opcodes 0..6 are defined; everything above is illegal
  function automatic logic op_legal(input logic [OPW-1:0] op);
    return (op <= 4'h6);
  endfunction

endpackage

// File: rtl/alu10.sv
// Combinational ALU used between the read and write phases.
module alu10
  import regfile_seq_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  op_t           op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          carry
);

  logic [DW:0] sum;

  // Result and carry/borrow per opcode; unused ops produce zero
  always_comb begin
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_STORE: result = a;
      OP_MOV:   result = b;
      OP_ADD: begin
        sum    = (DW+1)'(a) + (DW+1)'(b);
        result = sum[DW-1:0];
        carry  = sum[DW];
      end
      OP_SUB: begin
        result = a - b;
        carry  = (a < b);
      end
      OP_XOR:   result = a ^ b;
      OP_INC:   result = a + DW'(1);
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Sequences one register-transfer instruction through read, execute and
// write phases of the 4 x 10-bit register file (falling-edge design).
module regfile_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          CLKb,
  input  logic          Rst,
  input  logic          Start,
  input  logic [IW-1:0] Instr,
  input  logic [DW-1:0] Data,
  output logic          Busy,
  output logic          Done,
  output logic          Err,
  output logic          Carry,
  output logic [DW-1:0] Out,
  output logic          ENR0,
  output logic          ENR1,
  output logic [AW-1:0] RDA0,
  output logic [AW-1:0] RDA1,
  input  logic [DW-1:0] Q0,
  input  logic [DW-1:0] Q1,
  output logic          ENW,
  output logic [AW-1:0] WRA,
  output logic [DW-1:0] D
);

  instr_t instr_in;
  logic   unused_rsvd;
  logic   accept_c;

  state_t state_q, state_d;
  op_t    op_q, op_d;
  logic [AW_DEF-1:0] rx_q, rx_d, ry_q, ry_d;
  logic [DW-1:0] res_q, res_d, out_q, out_d;
  logic carry_q, carry_d, err_q, err_d;
  logic busy_q, busy_d, done_q, done_d, enr_q, enr_d, enw_q, enw_d;
  logic [AW-1:0] rda0_q, rda0_d, rda1_q, rda1_d, wra_q, wra_d;

  logic [DW-1:0] alu_res;
  logic          alu_carry;

  assign instr_in    = instr_t'(Instr);
  assign unused_rsvd = ^instr_in.rsvd;
  assign accept_c    = (state_q == S_IDLE) && Start;

  alu10 #(.DW(DW)) u_alu (
    .op     (op_q),
    .a      (Q0),
    .b      (Q1),
    .result (alu_res),
    .carry  (alu_carry)
  );

  // State register
  always_ff @(negedge CLKb or posedge Rst) begin
    if (Rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (!op_legal(instr_in.op))          state_d = S_DONE;
          else if (instr_in.op == OPW'(OP_LOAD)) state_d = S_WRITE;
          else                                 state_d = S_READ;
        end
      end
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = (op_q == OP_STORE) ? S_DONE : S_WRITE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control outputs decoded from the next state so they are registered with it
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    enr_d  = (state_d == S_READ);
    enw_d  = (state_d == S_WRITE);
    rda0_d = enr_d ? AW'(rx_d) : '0;
    rda1_d = enr_d ? AW'(ry_d) : '0;
    wra_d  = enw_d ? AW'(rx_d) : '0;
  end

  // Instruction latch, result, flags and STORE output
  always_comb begin
    op_d    = op_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    res_d   = res_q;
    out_d   = out_q;
    carry_d = carry_q;
    err_d   = err_q;
    if (accept_c) begin
      op_d  = op_t'(instr_in.op);
      rx_d  = instr_in.rx;
      ry_d  = instr_in.ry;
      err_d = !op_legal(instr_in.op);
      if (instr_in.op == OPW'(OP_LOAD)) res_d = Data;
    end
    if (state_q == S_EXEC) begin
      if (op_q == OP_STORE) out_d = Q0;
      else                  res_d = alu_res;
      if (op_q == OP_ADD || op_q == OP_SUB) carry_d = alu_carry;
    end
  end

  // Datapath and output registers; reset drops the port enables immediately
  always_ff @(negedge CLKb or posedge Rst) begin
    if (Rst) begin
      op_q    <= OP_LOAD;
      rx_q    <= '0;
      ry_q    <= '0;
      res_q   <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      enr_q   <= 1'b0;
      enw_q   <= 1'b0;
      rda0_q  <= '0;
      rda1_q  <= '0;
      wra_q   <= '0;
    end else begin
      op_q    <= op_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      res_q   <= res_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      enr_q   <= enr_d;
      enw_q   <= enw_d;
      rda0_q  <= rda0_d;
      rda1_q  <= rda1_d;
      wra_q   <= wra_d;
    end
  end

  assign Busy  = busy_q;
  assign Done  = done_q;
  assign Err   = err_q;
  assign Carry = carry_q;
  assign Out   = out_q;
  assign ENR0  = enr_q;
  assign ENR1  = enr_q;
  assign RDA0  = rda0_q;
  assign RDA1  = rda1_q;
  assign ENW   = enw_q;
  assign WRA   = wra_q;
  assign D     = res_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural register file.
module tb_regfile_sequencer;

  logic       clkb = 1'b1;
  logic       rst;
  logic       start;
  logic [9:0] instr;
  logic [9:0] data;
  logic       busy, done, err, carry;
  logic [9:0] out_v;
  logic       enr0, enr1, enw;
  logic [1:0] rda0, rda1, wra;
  logic [9:0] q0, q1, d;

  logic [9:0] mem [4];
  int checks   = 0;
  int failures = 0;
  int enw_cnt  = 0;
  int enr_cnt  = 0;
  int done_cnt = 0;

  regfile_sequencer dut (
    .CLKb  (clkb),
    .Rst   (rst),
    .Start (start),
    .Instr (instr),
    .Data  (data),
    .Busy  (busy),
    .Done  (done),
    .Err   (err),
    .Carry (carry),
    .Out   (out_v),
    .ENR0  (enr0),
    .ENR1  (enr1),
    .RDA0  (rda0),
    .RDA1  (rda1),
    .Q0    (q0),
    .Q1    (q1),
    .ENW   (enw),
    .WRA   (wra),
    .D     (d)
  );

  always #5 clkb = ~clkb;

  // Register file: writes and read captures on the falling edge
  always @(negedge clkb) begin
    if (enw)  mem[wra] <= d;
    if (enr0) q0 <= mem[rda0];
    if (enr1) q1 <= mem[rda1];
  end

  // Activity counters sampled mid-cycle
  always @(posedge clkb) begin
    if (enw === 1'b1)  enw_cnt  <= enw_cnt + 1;
    if (enr0 === 1'b1) enr_cnt  <= enr_cnt + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clkb);
    #1;
  endtask

  // Present one instruction for exactly one accepting edge, then scramble inputs
  task automatic issue(input logic [3:0] op, input logic [1:0] rx, input logic [1:0] ry,
                       input logic [9:0] dat);
    start = 1'b1;
    instr = {op, rx, ry, 2'b00};
    data  = dat;
    tick();
    start = 1'b0;
    instr = 10'h3FF;
    data  = 10'h000;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 8) begin
      tick();
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  int e0, r0, d0;

  initial begin
    rst = 1'b1; start = 1'b0; instr = '0; data = '0;
    tick();
    tick();
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_err",   32'(err),   32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_out",   32'(out_v), 32'd0);
    check("rst_enw",   32'(enw),   32'd0);
    check("rst_enr",   32'(enr0),  32'd0);
    check("rst_d",     32'(d),     32'd0);
    rst = 1'b0;
    tick();

    // LOAD R2 <= 0x155
    issue(4'h0, 2'd2, 2'd0, 10'h155);
    check("load_enw",  32'(enw),  32'd1);
    check("load_wra",  32'(wra),  32'd2);
    check("load_d",    32'(d),    32'h155);
    check("load_enr",  32'(enr0), 32'd0);
    check("load_busy", 32'(busy), 32'd1);
    tick();
    check("load_done", 32'(done),   32'd1);
    check("load_mem",  32'(mem[2]), 32'h155);
    tick();
    check("load_idle", 32'(busy), 32'd0);

    // ADD R1,R3 with R1=0x3FF, R3=0x001
    issue(4'h0, 2'd1, 2'd0, 10'h3FF); wait_idle("pre1");
    issue(4'h0, 2'd3, 2'd0, 10'h001); wait_idle("pre2");
    issue(4'h3, 2'd1, 2'd3, 10'h000);
    check("add_enr0", 32'(enr0), 32'd1);
    check("add_enr1", 32'(enr1), 32'd1);
    check("add_rda0", 32'(rda0), 32'd1);
    check("add_rda1", 32'(rda1), 32'd3);
    tick();
    check("add_exec_enr", 32'(enr0), 32'd0);
    check("add_exec_enw", 32'(enw),  32'd0);
    tick();
    check("add_enw",   32'(enw),   32'd1);
    check("add_wra",   32'(wra),   32'd1);
    check("add_d",     32'(d),     32'h000);
    check("add_carry", 32'(carry), 32'd1);
    tick();
    check("add_done", 32'(done),   32'd1);
    check("add_mem",  32'(mem[1]), 32'h000);
    wait_idle("add_idle");

    // SUB R0,R2 with R0=5, R2=7 -> 0x3FE with borrow
    issue(4'h0, 2'd0, 2'd0, 10'd5); wait_idle("pre3");
    issue(4'h0, 2'd2, 2'd0, 10'd7); wait_idle("pre4");
    issue(4'h4, 2'd0, 2'd2, 10'h000);
    tick();
    tick();
    check("sub_d",     32'(d),     32'h3FE);
    check("sub_carry", 32'(carry), 32'd1);
    wait_idle("sub_idle");
    check("sub_mem", 32'(mem[0]), 32'h3FE);

    // STORE R0: Out valid at n+2, no write
    e0 = enw_cnt;
    issue(4'h1, 2'd0, 2'd0, 10'h000);
    tick();
    tick();
    check("store_out",  32'(out_v), 32'h3FE);
    check("store_done", 32'(done),  32'd1);
    wait_idle("store_idle");
    check("store_noenw",  32'(enw_cnt), 32'(e0));
    check("store_carry",  32'(carry),   32'd1);

    // Illegal opcode 1111
    e0 = enw_cnt; r0 = enr_cnt;
    issue(4'hF, 2'd1, 2'd2, 10'h000);
    check("ill_done", 32'(done), 32'd1);
    check("ill_err",  32'(err),  32'd1);
    check("ill_enr",  32'(enr0), 32'd0);
    check("ill_enw",  32'(enw),  32'd0);
    tick();
    check("ill_idle",    32'(busy),    32'd0);
    check("ill_err_hold", 32'(err),    32'd1);
    check("ill_noenw",   32'(enw_cnt), 32'(e0));
    check("ill_noenr",   32'(enr_cnt), 32'(r0));
    issue(4'h0, 2'd3, 2'd0, 10'h2AA);
    check("err_clear", 32'(err), 32'd0);
    wait_idle("ld3_idle");

    // MOV R0 <= R3, with a Start pulse during READ that must be ignored
    d0 = done_cnt;
    issue(4'h2, 2'd0, 2'd3, 10'h000);
    start = 1'b1; instr = {4'h0, 2'd0, 2'd0, 2'b00}; data = 10'h111;
    tick();
    start = 1'b0; instr = 10'h3FF; data = 10'h000;
    tick();
    check("mov_d", 32'(d), 32'h2AA);
    wait_idle("mov_idle");
    check("mov_one_done", 32'(done_cnt - d0), 32'd1);
    check("mov_mem",      32'(mem[0]),        32'h2AA);

    // XOR R0,R1 with R1=0x0F0
    issue(4'h0, 2'd1, 2'd0, 10'h0F0); wait_idle("pre5");
    issue(4'h5, 2'd0, 2'd1, 10'h000);
    wait_idle("xor_idle");
    check("xor_mem",   32'(mem[0]), 32'h25A);
    check("xor_carry", 32'(carry),  32'd1);

    // SUB R3,R3: same register on both ports
    issue(4'h4, 2'd3, 2'd3, 10'h000);
    wait_idle("subeq_idle");
    check("subeq_mem",   32'(mem[3]), 32'h000);
    check("subeq_carry", 32'(carry),  32'd0);

    // INC R3 aborted by reset in WRITE
    issue(4'h6, 2'd3, 2'd0, 10'h000);
    tick();
    tick();
    check("inc_enw", 32'(enw), 32'd1);
    check("inc_d",   32'(d),   32'h001);
    rst = 1'b1;
    #1;
    check("rst_async_enw",  32'(enw),  32'd0);
    check("rst_async_busy", 32'(busy), 32'd0);
    tick();
    check("inc_aborted", 32'(mem[3]), 32'h000);
    rst = 1'b0;
    tick();

    // Sequencer functional again after reset
    issue(4'h0, 2'd1, 2'd0, 10'h0AB);
    wait_idle("post_idle");
    check("post_mem", 32'(mem[1]), 32'h0AB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Initiator-side controller for the 4 x 10-bit register file. It accepts one register-transfer instruction at a time over a Start/Done handshake and drives the register file's read ports (ENR0/ENR1/RDA0/RDA1) and write port (ENW/WRA/D) in the correct cycle order. Between read and write it computes the result with a small 10-bit ALU. It sits between the instruction decode/bus logic and the register file, and is the only block that drives the register file's control pins.

## Interface
Parameters:
- DW, 10, datapath width (matches register file)
- AW, 2, register address width

Ports:
- CLKb  in  1  clock; all state updates on falling edge (same edge as register file)
- Rst  in  1  reset, asynchronous, active-high
- Start  in  1  request; sampled only in IDLE
- Instr  in  10  [9:6] op, [5:4] Rx (destination/first source), [3:2] Ry (second source), [1:0] ignored
- Data  in  DW  immediate for LOAD
- Busy  out  1  high in every state except IDLE
- Done  out  1  one-cycle pulse in DONE state
- Err  out  1  illegal opcode flag
- Carry  out  1  carry/borrow of last ADD/SUB
- Out  out  DW  value of Rx after STORE
- ENR0, ENR1  out  1  register file read enables
- RDA0, RDA1  out  AW  read addresses
- Q0, Q1  in  DW  register file read data
- ENW  out  1  register file write enable
- WRA  out  AW  write address
- D  out  DW  write data

## Operation
- Opcodes: 0000 LOAD Rx<=Data; 0001 STORE Out<=Rx; 0010 MOV Rx<=Ry; 0011 ADD Rx<=Rx+Ry; 0100 SUB Rx<=Rx-Ry; 0101 XOR Rx<=Rx^Ry; 0110 INC Rx<=Rx+1; all others are illegal.
- Instr and Data are latched at the accepting edge. Later input changes have no effect on the instruction in progress.
- States and transitions:
  - IDLE: if Start, go to WRITE (LOAD), READ (legal non-LOAD op), or DONE (illegal op).
  - READ -> EXEC.
  - EXEC -> DONE (STORE) or WRITE (all other ops).
  - WRITE -> DONE.
  - DONE -> IDLE.
- READ: ENR0=1, RDA0=Rx; ENR1=1, RDA1=Ry. Read enables are low in every other state.
- EXEC: the ALU consumes Q0/Q1; the result is registered at the EXEC exit edge. STORE loads Out from Q0 at that edge.
- WRITE: ENW=1, WRA=Rx, D=result register (Data for LOAD). ENW is low in all other states.
- Arithmetic is modulo 2^10. ADD: Carry = bit 10 of the 11-bit sum. SUB: Carry = 1 when Rx<Ry (borrow). Other ops leave Carry unchanged.
- Err is set on an illegal op, cleared at the next accepted Start, and persists otherwise. An illegal op never asserts ENR or ENW.
- Reset values: state IDLE, all outputs 0, latched instruction/result 0.

## Timing
- Edge n = the accepting falling edge.
- LOAD: WRITE during n..n+1, write commits at n+1, Done high during n+1..n+2. Busy for 2 cycles.
- MOV/ADD/SUB/XOR/INC: READ n..n+1, EXEC n+1..n+2, WRITE n+2..n+3, Done during n+3..n+4. 4 busy cycles.
- STORE: Out valid from edge n+2 and held until the next STORE. Done during n+2..n+3.
- Illegal op: Done and Err high during n..n+1.
- Start while Busy is ignored; there is no queueing. Start held high continuously starts a new instruction at the first IDLE edge.
- Rx==Ry is legal: both ports read the same register. SUB yields 0, Carry=0.
- Rst mid-operation: ENW/ENR drop immediately (asynchronously). The pending write is aborted and register file contents are not affected.

## Structure
- Package regfile_seq_pkg holds:
  - op_t enum (4-bit opcodes above)
  - state_t enum (IDLE, READ, EXEC, WRITE, DONE)
  - Instr field positions
  - DW/AW defaults
- Sub-module alu10: combinational, inputs op, a, b; outputs result[DW-1:0] and carry. Instantiated once.

## Test plan
- LOAD R2 with Data=10'h155: ENW=1, WRA=2, D=10'h155 in the second cycle; register file model holds R2=10'h155; Done 2 cycles after Start.
- R1=10'h3FF, R3=10'h001, ADD R1,R3: R1=10'h000, Carry=1, Done at n+3.
- R0=5, R2=7, SUB R0,R2: R0=10'h3FE, Carry=1. Then STORE R0: Out=10'h3FE, ENW never asserted.
- Opcode 1111: Err=1 and Done within 1 cycle, no ENR/ENW. Next LOAD clears Err.
- Start pulsed during READ of a MOV: ignored, only one Done. Then Rst asserted in WRITE of an INC: ENW=0 immediately, target register unchanged, Busy=0.
